// File: rtl/cpu_pkg.sv
// Shared constants, fetch FSM state type and branch-offset helpers for the LEGv8 pipeline.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

    // imm26 (B/BL) sign-extended to ADDR_W and scaled to a byte offset
    function automatic logic [ADDR_W-1:0] se26_sl2(input logic [25:0] imm);
        return {{(ADDR_W-28){imm[25]}}, imm, 2'b00};
    endfunction

    // imm19 (CBZ/CBNZ/B.cond) sign-extended to ADDR_W and scaled to a byte offset
    function automatic logic [ADDR_W-1:0] se19_sl2(input logic [18:0] imm);
        return {{(ADDR_W-21){imm[18]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: per-bit D flip-flops with a 2:1 hold mux, plus a squashable valid bit.
module d_ff (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) q <= rst_val;
        else       q <= d;
    end
endmodule

module ifid_reg #(
    parameter int unsigned            ADDR_W  = 64,
    parameter int unsigned            INSTR_W = 32,
    parameter logic [ADDR_W-1:0]      RST_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               squash,
    input  logic [ADDR_W-1:0]  pc_d,
    input  logic [INSTR_W-1:0] instr_d,
    output logic [ADDR_W-1:0]  pc_q,
    output logic [INSTR_W-1:0] instr_q,
    output logic               valid_q
);
    localparam logic [INSTR_W-1:0] RST_INSTR = '0;

    for (genvar i = 0; i < ADDR_W; i++) begin : g_pc
        d_ff u_ff (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RST_PC[i]),
            .d       (hold ? pc_q[i] : pc_d[i]),
            .q       (pc_q[i])
        );
    end

    for (genvar i = 0; i < INSTR_W; i++) begin : g_instr
        d_ff u_ff (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RST_INSTR[i]),
            .d       (hold ? instr_q[i] : instr_d[i]),
            .q       (instr_q[i])
        );
    end

    // A squashed capture still loads pc/instr; only valid is cleared
    d_ff u_valid (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b0),
        .d       (hold ? valid_q : ~squash),
        .q       (valid_q)
    );
endmodule

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: next-PC selection (sequential / branch redirect / stall), boot FSM and IF/ID capture.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic [ADDR_W-1:0]  pc_next,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               br_taken,
    input  logic               br_uncond,
    input  logic               br_reg,
    input  logic [ADDR_W-1:0]  br_reg_val,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid
);
    fetch_state_t      state, next_state;
    logic [ADDR_W-1:0] pc_seq, br_offset, br_target;
    logic              hold, squash;

    assign pc_seq    = pc_cur + ADDR_W'(4);
    assign br_offset = br_uncond ? se26_sl2(ifid_instr[25:0]) : se19_sl2(ifid_instr[23:5]);
    // Branch target is relative to the branch's own PC, held in IF/ID
    assign br_target = br_reg ? br_reg_val : (ifid_pc + br_offset);

    always_ff @(posedge clk) begin
        if (reset) state <= BOOT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pc_next    = pc_seq;
        hold       = 1'b0;
        squash     = 1'b0;
        if (reset) begin
            next_state = BOOT;
            pc_next    = RST_PC;
        end else begin
            unique case (state)
                BOOT: next_state = RUN;
                RUN: begin
                    if (stall) begin
                        hold    = 1'b1;
                        pc_next = pc_cur;
                    end else if (br_taken && ifid_valid) begin
                        squash  = 1'b1;
                        pc_next = br_target;
                    end
                end
                default: next_state = BOOT;
            endcase
        end
    end

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RST_PC  (RST_PC)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .squash  (squash),
        .pc_d    (pc_cur),
        .instr_d (imem_instr),
        .pc_q    (ifid_pc),
        .instr_q (ifid_instr),
        .valid_q (ifid_valid)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage closed through a behavioural PC register and instruction memory.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_cur, pc_next;
    logic [31:0] imem_instr;
    logic        stall, br_taken, br_uncond, br_reg;
    logic [63:0] br_reg_val;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;

    logic        force_en;
    logic [63:0] force_val;
    logic        imem_ovr_en;
    logic [31:0] imem_ovr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // PC register; force path lets the bench place the PC anywhere
    always @(posedge clk) pc_cur <= force_en ? force_val : pc_next;

    always_comb imem_instr = imem_ovr_en ? imem_ovr : {16'hD503, pc_cur[15:0]};

    fetch_stage #(
        .ADDR_W  (64),
        .INSTR_W (32),
        .RST_PC  (64'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .imem_instr (imem_instr),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_uncond  (br_uncond),
        .br_reg     (br_reg),
        .br_reg_val (br_reg_val),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        stall = 0; br_taken = 0; br_uncond = 0; br_reg = 0; br_reg_val = '0;
        force_en = 0; force_val = '0; imem_ovr_en = 0; imem_ovr = '0;
    endtask

    // Leaves IF/ID = {pc, instr, valid=1} and pc_cur = pc + 4
    task automatic load_branch(input logic [63:0] pc, input logic [31:0] instr);
        br_taken = 0; stall = 0;
        force_en = 1; force_val = pc;
        step;
        force_en = 0; imem_ovr_en = 1; imem_ovr = instr;
        step;
        imem_ovr_en = 0;
    endtask

    task automatic test_reset;
        clear_inputs;
        reset = 1;
        step; step;
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", ifid_valid); end
        checks++; if (ifid_pc !== 64'd0) begin failures++; $display("FAIL rst_ifid_pc: got %h expected 0", ifid_pc); end
        checks++; if (ifid_instr !== 32'd0) begin failures++; $display("FAIL rst_ifid_instr: got %h expected 0", ifid_instr); end
        checks++; if (pc_next !== 64'd0) begin failures++; $display("FAIL rst_pc_next: got %h expected 0", pc_next); end
        reset = 0;
        #1;
        checks++; if (pc_cur !== 64'd0) begin failures++; $display("FAIL boot_pc_cur: got %h expected 0", pc_cur); end
        checks++; if (pc_next !== 64'd4) begin failures++; $display("FAIL boot_pc_next: got %h expected 4", pc_next); end
        for (int k = 1; k <= 3; k++) begin
            step;
            checks++; if (pc_cur !== 64'(4*k)) begin failures++; $display("FAIL seq_pc_cur[%0d]: got %h expected %h", k, pc_cur, 64'(4*k)); end
            checks++; if (ifid_pc !== 64'(4*(k-1))) begin failures++; $display("FAIL seq_ifid_pc[%0d]: got %h expected %h", k, ifid_pc, 64'(4*(k-1))); end
            checks++; if (ifid_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, ifid_valid); end
        end
        checks++; if (ifid_instr !== 32'hD503_0008) begin failures++; $display("FAIL seq_instr: got %h expected D5030008", ifid_instr); end
    endtask

    task automatic test_stall;
        clear_inputs;
        reset = 1; step; step; reset = 0;
        step; step;
        stall = 1;
        #1;
        checks++; if (pc_next !== 64'd8) begin failures++; $display("FAIL stall_pc_next: got %h expected 8", pc_next); end
        for (int k = 0; k < 3; k++) begin
            step;
            checks++; if (pc_cur !== 64'd8) begin failures++; $display("FAIL stall_pc_cur[%0d]: got %h expected 8", k, pc_cur); end
            checks++; if (ifid_pc !== 64'd4 || ifid_valid !== 1'b1 || ifid_instr !== 32'hD503_0004) begin
                failures++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b expected 4/D5030004/1", k, ifid_pc, ifid_instr, ifid_valid);
            end
        end
        stall = 0;
        step;
        checks++; if (pc_cur !== 64'd12) begin failures++; $display("FAIL unstall_pc_cur: got %h expected c", pc_cur); end
        checks++; if (ifid_pc !== 64'd8) begin failures++; $display("FAIL unstall_ifid_pc: got %h expected 8", ifid_pc); end
    endtask

    task automatic test_branch_uncond;
        clear_inputs;
        load_branch(64'h10, 32'h1400_0003);
        br_taken = 1; br_uncond = 1;
        #1;
        checks++; if (pc_next !== 64'h1C) begin failures++; $display("FAIL b_fwd_target: got %h expected 1c", pc_next); end
        step;
        checks++; if (pc_cur !== 64'h1C) begin failures++; $display("FAIL b_fwd_pc_cur: got %h expected 1c", pc_cur); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL b_fwd_squash: got %b expected 0", ifid_valid); end
        // br_taken still high but IF/ID holds a bubble: must fall through to sequential
        checks++; if (pc_next !== 64'h20) begin failures++; $display("FAIL b_invalid_ignored: got %h expected 20", pc_next); end
        load_branch(64'h10, 32'h17FF_FFFF);
        br_taken = 1; br_uncond = 1;
        #1;
        checks++; if (pc_next !== 64'h0C) begin failures++; $display("FAIL b_back_target: got %h expected c", pc_next); end
        step;
        checks++; if (pc_cur !== 64'h0C || ifid_valid !== 1'b0) begin
            failures++; $display("FAIL b_back_redirect: got %h/%b expected c/0", pc_cur, ifid_valid);
        end
        br_taken = 0;
    endtask

    task automatic test_cbz_br;
        clear_inputs;
        load_branch(64'h40, 32'hB4FF_FFC0);
        br_taken = 1; br_uncond = 0;
        #1;
        checks++; if (pc_next !== 64'h38) begin failures++; $display("FAIL cbz_target: got %h expected 38", pc_next); end
        step;
        checks++; if (pc_cur !== 64'h38) begin failures++; $display("FAIL cbz_pc_cur: got %h expected 38", pc_cur); end
        load_branch(64'h100, 32'hD61F_0000);
        br_taken = 1; br_reg = 1; br_uncond = 1; br_reg_val = 64'hDEAD_0000;
        step;
        checks++; if (pc_cur !== 64'hDEAD_0000) begin failures++; $display("FAIL br_pc_cur: got %h expected dead0000", pc_cur); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL br_squash: got %b expected 0", ifid_valid); end
        br_taken = 0; br_reg = 0;
    endtask

    task automatic test_stall_branch;
        clear_inputs;
        load_branch(64'h10, 32'h1400_0003);
        stall = 1; br_taken = 1; br_uncond = 1;
        #1;
        checks++; if (pc_next !== 64'h14) begin failures++; $display("FAIL stbr_pc_next: got %h expected 14", pc_next); end
        step;
        checks++; if (pc_cur !== 64'h14 || ifid_pc !== 64'h10 || ifid_valid !== 1'b1) begin
            failures++; $display("FAIL stbr_hold: got %h/%h/%b expected 14/10/1", pc_cur, ifid_pc, ifid_valid);
        end
        stall = 0;
        #1;
        checks++; if (pc_next !== 64'h1C) begin failures++; $display("FAIL stbr_release_target: got %h expected 1c", pc_next); end
        step;
        checks++; if (pc_cur !== 64'h1C || ifid_valid !== 1'b0) begin
            failures++; $display("FAIL stbr_redirect: got %h/%b expected 1c/0", pc_cur, ifid_valid);
        end
        br_taken = 0;
    endtask

    task automatic test_midrun_reset;
        clear_inputs;
        force_en = 1; force_val = 64'h80;
        step;
        force_en = 0;
        step;
        checks++; if (ifid_pc !== 64'h80 || ifid_valid !== 1'b1) begin
            failures++; $display("FAIL mid_pre: got %h/%b expected 80/1", ifid_pc, ifid_valid);
        end
        reset = 1;
        #1;
        checks++; if (pc_next !== 64'd0) begin failures++; $display("FAIL mid_rst_pc_next: got %h expected 0", pc_next); end
        step;
        reset = 0;
        #1;
        checks++; if (pc_cur !== 64'd0 || ifid_valid !== 1'b0) begin
            failures++; $display("FAIL mid_rst_state: got %h/%b expected 0/0", pc_cur, ifid_valid);
        end
        checks++; if (dut.state !== BOOT) begin failures++; $display("FAIL mid_rst_fsm: got %0d expected BOOT", dut.state); end
        checks++; if (pc_next !== 64'd4) begin failures++; $display("FAIL mid_boot_pc_next: got %h expected 4", pc_next); end
        step;
        force_en = 1; force_val = 64'hFFFF_FFFF_FFFF_FFFC;
        step;
        force_en = 0;
        #1;
        checks++; if (pc_next !== 64'd0) begin failures++; $display("FAIL wrap_pc_next: got %h expected 0", pc_next); end
        step;
        checks++; if (pc_cur !== 64'd0 || ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_valid !== 1'b1) begin
            failures++; $display("FAIL wrap_capture: got %h/%h/%b expected 0/fffffffffffffffc/1", pc_cur, ifid_pc, ifid_valid);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs;
        test_reset;
        test_stall;
        test_branch_uncond;
        test_cbz_br;
        test_stall_branch;
        test_midrun_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end
endmodule
